// File: rtl/pixel_write_arbiter_if.sv
// Pixel-write requester bus plus Avalon-MM write master, grouped for the arbiter.
interface pixel_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_address;
  logic [NUM_REQ-1:0][15:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [31:0]              m1_address;
  logic [15:0]              m1_writedata;
  logic                     m1_write;
  logic                     m1_waitrequest;

  // Arbiter side: accepts requests, drives the Avalon write master.
  modport master (
    input  req_valid, req_address, req_data, m1_waitrequest,
    output req_ready, m1_address, m1_writedata, m1_write
  );

  // Environment side: shader requesters and the Avalon slave.
  modport slave (
    output req_valid, req_address, req_data, m1_waitrequest,
    input  req_ready, m1_address, m1_writedata, m1_write
  );
endinterface

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter funnelling shader pixel writes onto one Avalon-MM write
// master, with zero-bubble back-to-back issue and a stall timeout.
module pixel_write_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  pixel_write_arbiter_if.master bus,
  input  logic                  error_clear,
  output logic                  error,
  output logic                  busy,
  output logic [31:0]           writes_done
);
  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [31:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic [31:0]        done_q, done_d;
  logic               err_q, err_d;

  logic [PTR_W-1:0]   sel_idx;
  logic               sel_found;
  logic               stalled_c, timeout_c, capture_en_c;
  logic [NUM_REQ-1:0] grant_c;

  // Rotating priority search starting at ptr.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand      = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state, capture, completion counting and timeout handling.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    stall_d  = stall_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = done_q;
    err_d    = err_q;
    grant_c  = '0;

    stalled_c    = (state_q == WRITE) && bus.m1_waitrequest;
    timeout_c    = stalled_c && (stall_q == CNT_W'(TIMEOUT - 1));
    capture_en_c = ((state_q == IDLE) || !bus.m1_waitrequest) && !timeout_c;

    if (error_clear) err_d = 1'b0;
    if ((state_q == WRITE) && !bus.m1_waitrequest) done_d = done_q + 32'd1;
    if (stalled_c) stall_d = stall_q + CNT_W'(1);

    if (timeout_c) begin
      // Abandon the stuck write; the set below overrides any clear.
      state_d = IDLE;
      stall_d = '0;
      err_d   = 1'b1;
    end else if (capture_en_c) begin
      if (sel_found) begin
        grant_c[sel_idx] = 1'b1;
        state_d = WRITE;
        stall_d = '0;
        ptr_d   = PTR_W'((32'(sel_idx) + 32'd1) % NUM_REQ);
        addr_d  = bus.req_address[sel_idx];
        data_d  = bus.req_data[sel_idx];
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      stall_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready    = reset ? '0 : grant_c;
  assign bus.m1_write     = (state_q == WRITE);
  assign bus.m1_address   = addr_q;
  assign bus.m1_writedata = data_q;
  assign busy             = (state_q == WRITE);
  assign error            = err_q;
  assign writes_done      = done_q;
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter: vector table plus stall, timeout
// and asynchronous-reset sequences.
module tb_pixel_write_arbiter;
  logic        clk;
  logic        reset;
  logic        error_clear;
  logic        error;
  logic        busy;
  logic [31:0] writes_done;

  pixel_write_arbiter_if #(.NUM_REQ(4)) bus ();

  pixel_write_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clock       (clk),
    .reset       (reset),
    .bus         (bus),
    .error_clear (error_clear),
    .error       (error),
    .busy        (busy),
    .writes_done (writes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] addr_tab [4];
  logic [15:0] data_tab [4];

  typedef struct {
    logic [3:0]  valid;
    logic        wreq;
    logic [3:0]  rdy;
    logic        wr;
    int          idx;
    logic [31:0] done;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Apply inputs, check req_ready before the edge, then registered outputs after it.
  task automatic step(input string nm, input logic [3:0] v, input logic w, input logic clr,
                      input logic [3:0] exp_rdy, input logic exp_wr, input int exp_idx,
                      input logic [31:0] exp_done, input logic exp_err);
    logic [1:0] k;
    bus.req_valid      = v;
    bus.m1_waitrequest = w;
    error_clear        = clr;
    #1;
    check($sformatf("%s.req_ready", nm), 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    check($sformatf("%s.m1_write", nm), 32'(bus.m1_write), 32'(exp_wr));
    check($sformatf("%s.busy", nm), 32'(busy), 32'(exp_wr));
    if (exp_idx >= 0) begin
      k = exp_idx[1:0];
      check($sformatf("%s.m1_address", nm), bus.m1_address, addr_tab[k]);
      check($sformatf("%s.m1_writedata", nm), 32'(bus.m1_writedata), 32'(data_tab[k]));
    end
    check($sformatf("%s.writes_done", nm), writes_done, exp_done);
    check($sformatf("%s.error", nm), 32'(error), 32'(exp_err));
  endtask

  initial begin
    addr_tab[0] = 32'h0800_0000; data_tab[0] = 16'hAAAA;
    addr_tab[1] = 32'h0800_0008; data_tab[1] = 16'hBBBB;
    addr_tab[2] = 32'h0800_0010; data_tab[2] = 16'h1111;
    addr_tab[3] = 32'h0800_0018; data_tab[3] = 16'hCCCC;

    //            valid    wreq  rdy      wr    idx done
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1,  2, 32'd0};
    vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd1};
    vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1,  3, 32'd1};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1,  0, 32'd2};
    vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 1'b1,  1, 32'd3};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 1'b1,  2, 32'd4};
    vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 1'b1,  3, 32'd5};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 1'b1,  0, 32'd6};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1,  0, 32'd6};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd7};
    vecs[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1,  3, 32'd7};
    vecs[12] = '{4'b1001, 1'b1, 4'b0000, 1'b1,  3, 32'd7};
    vecs[13] = '{4'b0011, 1'b0, 4'b0001, 1'b1,  0, 32'd8};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, -1, 32'd9};

    for (int i = 0; i < 4; i++) begin
      bus.req_address[i] = addr_tab[i];
      bus.req_data[i]    = data_tab[i];
    end

    // Reset: outputs cleared, no grants even with every requester valid.
    reset              = 1'b1;
    error_clear        = 1'b0;
    bus.req_valid      = 4'b1111;
    bus.m1_waitrequest = 1'b0;
    #1;
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.m1_write", 32'(bus.m1_write), 32'd0);
    check("rst.m1_address", bus.m1_address, 32'd0);
    check("rst.m1_writedata", 32'(bus.m1_writedata), 32'd0);
    check("rst.writes_done", writes_done, 32'd0);
    check("rst.error", 32'(error), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.m1_write", 32'(bus.m1_write), 32'd0);
    check("rst_hold.req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 4'b0000;

    // Single request, round-robin, mixed stall/idle vectors.
    for (int i = 0; i < 15; i++)
      step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].wreq, 1'b0,
           vecs[i].rdy, vecs[i].wr, vecs[i].idx, vecs[i].done, 1'b0);

    // Seven stalled cycles on requester 2, others waving valid, done on the 8th.
    step("stall.grant", 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2, 32'd9, 1'b0);
    for (int i = 0; i < 7; i++)
      step($sformatf("stall%0d", i), 4'b1011, 1'b1, 1'b0, 4'b0000, 1'b1, 2, 32'd9, 1'b0);
    step("stall.done", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, 32'd10, 1'b0);

    // Timeout after 16 stalled cycles; no capture on the timeout cycle.
    step("to.grant", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 32'd10, 1'b0);
    for (int i = 0; i < 15; i++)
      step($sformatf("to%0d", i), 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1, 32'd10, 1'b0);
    step("to.fire", 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 32'd10, 1'b1);
    step("to.sticky", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, -1, 32'd10, 1'b1);
    step("to.clear", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, -1, 32'd10, 1'b0);
    step("to.cleared", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, 32'd10, 1'b0);

    // Second timeout with error_clear held: set wins on the timeout edge.
    step("to2.grant", 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 0, 32'd10, 1'b0);
    for (int i = 0; i < 15; i++)
      step($sformatf("to2_%0d", i), 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 0, 32'd10, 1'b0);
    step("to2.fire", 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, -1, 32'd10, 1'b1);
    step("to2.sticky", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, 32'd10, 1'b1);

    // Reset mid-write takes effect without a clock edge; ptr restarts at 0.
    step("rmw.grant", 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2, 32'd10, 1'b1);
    step("rmw.stall", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2, 32'd10, 1'b1);
    bus.req_valid = 4'b1010;
    #2;
    reset = 1'b1;
    #1;
    check("rmw.m1_write", 32'(bus.m1_write), 32'd0);
    check("rmw.busy", 32'(busy), 32'd0);
    check("rmw.req_ready", 32'(bus.req_ready), 32'd0);
    check("rmw.m1_address", bus.m1_address, 32'd0);
    check("rmw.writes_done", writes_done, 32'd0);
    check("rmw.error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("rmw.first", 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 1, 32'd0, 1'b0);
    step("rmw.done", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, -1, 32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of shader write requesters (2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1024, max consecutive waitrequest cycles per write (>=2).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester pixel-write request.
REQ-006 SHALL have port req_address  in  NUM_REQ x 32  per-requester byte address.
REQ-007 SHALL have port req_data  in  NUM_REQ x 16  per-requester pixel data.
REQ-008 SHALL have port req_ready  out  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port m1_address  out  32  Avalon-MM master address.
REQ-010 SHALL have port m1_writedata  out  16  Avalon-MM master write data.
REQ-011 SHALL have port m1_write  out  1  Avalon-MM write strobe.
REQ-012 SHALL have port m1_waitrequest  in  1  slave stall.
REQ-013 SHALL have port error_clear  in  1  clears sticky error.
REQ-014 SHALL have port error  out  1  sticky timeout flag.
REQ-015 SHALL have port busy  out  1  high while m1_write is high.
REQ-016 SHALL have port writes_done  out  32  count of completed writes.

Function
REQ-017 SHALL implement two states: IDLE (m1_write=0) and WRITE (m1_write=1).
REQ-018 SHALL define capture_en = (state==IDLE) or (state==WRITE and !m1_waitrequest) and no timeout this cycle.
REQ-019 SHALL select, when capture_en and any req_valid, the first asserted index searching ptr, ptr+1, ... mod NUM_REQ.
REQ-020 SHALL drive req_ready combinationally: bit g high only for selected index g in a capture_en cycle; all others 0.
REQ-021 SHALL, at the edge ending a req_ready[g] cycle, register req_address[g]/req_data[g] into m1_address/m1_writedata, set m1_write=1, enter WRITE, set ptr=(g+1) mod NUM_REQ.
REQ-022 SHALL hold m1_address, m1_writedata, m1_write stable while m1_waitrequest=1.
REQ-023 SHALL count a write complete on any edge where m1_write=1 and m1_waitrequest=0; writes_done +1, wrapping 2^32-1 -> 0.
REQ-024 SHALL, on completion with another req_valid present, capture the next request on the same edge (zero-bubble back-to-back).
REQ-025 SHALL, on completion with no req_valid, return to IDLE with m1_write=0 on that edge.
REQ-026 SHALL count consecutive cycles with m1_write=1 and m1_waitrequest=1; reset the count on each capture.
REQ-027 SHALL, when that count reaches TIMEOUT, on that edge drop m1_write, go IDLE, set error=1, not increment writes_done, not capture (req_ready all 0 that cycle).
REQ-028 SHALL keep error set until error_clear=1 sampled; set wins over clear on the same edge.
REQ-029 SHALL ignore req_valid changes on non-selected requesters; requesters hold address/data until req_ready.
REQ-030 SHALL keep busy equal to m1_write.

Reset
REQ-031 SHALL, on reset assertion, immediately (asynchronously) force state=IDLE, m1_write=0, m1_address=0, m1_writedata=0, ptr=0, error=0, writes_done=0, timeout count=0.
REQ-032 SHALL drive req_ready all 0 while reset is high; reset mid-WRITE abandons the write without counting it.

Verification
REQ-033 Single request: req_valid=4'b0100, addr 0x0800_0010, data 0x1111, waitrequest=0 -> req_ready=4'b0100 one cycle; next cycle m1_write=1, m1_address=0x0800_0010; writes_done=1 after one beat.
REQ-034 Round-robin: all four valid continuously, waitrequest=0 -> grants 0,1,2,3,0 on consecutive cycles, m1_write continuously high, writes_done=5 after 5 beats.
REQ-035 Stall: waitrequest=1 for 7 cycles during write of req 2 -> m1_address/m1_writedata unchanged 7 cycles, no req_ready pulses, completion on 8th cycle.
REQ-036 Timeout: TIMEOUT=16, waitrequest stuck 1 -> after 16 stalled cycles m1_write=0, error=1, writes_done unchanged; error_clear pulse -> error=0.
REQ-037 Reset mid-write: assert reset while m1_write=1 with waitrequest=1 -> m1_write=0 without waiting for an edge; after release, first grant goes to lowest valid index (ptr=0).
